// File: rtl/mem_state_mover.sv
// Moves a paged, channel-interleaved memory region out to a save stream
// and back in from a restore stream, with optional byte de-interleave.
module mem_state_mover #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 32,
  parameter int NUM_CH = 4,
  parameter int PAGE_WORDS = 128,
  parameter int PAGE_COUNT = 128,
  parameter logic [ADDR_W-1:0] START_ADDRESS = '0,
  parameter int SWAP_BYTES = 1,
  parameter int FIFO_DEPTH = 8,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              save,
  input  logic              restore,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_we,
  output logic [CH_W-1:0]   mem_cmd_ch,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic              dout_last,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [DATA_W-1:0] din_data,
  input  logic              din_last
);

  localparam int CH_SH = $clog2(NUM_CH);
  localparam int PW_W = (PAGE_WORDS > 1) ? $clog2(PAGE_WORDS) : 1;
  localparam int FP_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = FP_W + 1;
  localparam int HB = DATA_W / 16;
  localparam logic [PW_W-1:0] LAST_WORD = PW_W'(PAGE_WORDS - 1);
  localparam logic [15:0] LAST_PAGE = 16'(PAGE_COUNT - 1);
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] CH_MASK = ADDR_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE,
    ST_SAVE_DRAIN,
    ST_RESTORE,
    ST_DONE
  } state_e;

  state_e state_q, state_d;
  logic save_q, save_d;
  logic restore_q, restore_d;
  logic error_q, error_d;
  logic [ADDR_W-1:0] lin_addr_q, lin_addr_d;
  logic [PW_W-1:0] cmd_word_q, cmd_word_d;
  logic [15:0] cmd_page_q, cmd_page_d;
  logic [PW_W-1:0] out_word_q, out_word_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FP_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FP_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];

  logic save_rise;
  logic rest_rise;
  logic page_end;
  logic cmd_last;
  logic can_issue;
  logic cmd_fire;
  logic rd_fire;
  logic rd_ok;
  logic pop;
  logic [CNT_W:0] in_flight;
  logic [DATA_W-1:0] head;

  // Upper half gathers odd bytes, lower half even bytes, both highest first.
  function automatic logic [DATA_W-1:0] swap_fwd(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int j = 0; j < HB; j++) begin
      r[8*j +: 8] = w[16*j +: 8];
      r[8*(HB+j) +: 8] = w[16*j+8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] swap_inv(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int j = 0; j < HB; j++) begin
      r[16*j +: 8] = w[8*j +: 8];
      r[16*j+8 +: 8] = w[8*(HB+j) +: 8];
    end
    return r;
  endfunction

  assign error = error_q;
  assign mem_cmd_ch = CH_W'(lin_addr_q & CH_MASK);
  assign mem_cmd_addr = lin_addr_q >> CH_SH;
  assign head = fifo_mem_q[rd_ptr_q];
  assign dout_data = (SWAP_BYTES != 0) ? swap_fwd(head) : head;

  always_comb begin
    state_d = state_q;
    error_d = error_q;
    save_d = save;
    restore_d = restore;
    lin_addr_d = lin_addr_q;
    cmd_word_d = cmd_word_q;
    cmd_page_d = cmd_page_q;
    out_word_d = out_word_q;
    busy = 1'b1;
    done = 1'b0;
    mem_cmd_valid = 1'b0;
    mem_cmd_we = 1'b0;
    mem_wdata = '0;
    din_ready = 1'b0;
    dout_valid = 1'b0;
    save_rise = save & ~save_q;
    rest_rise = restore & ~restore_q;
    page_end = (cmd_word_q == LAST_WORD);
    cmd_last = page_end && (cmd_page_q == LAST_PAGE);
    in_flight = {1'b0, outst_q} + {1'b0, cnt_q};
    can_issue = (in_flight < DEPTH_V);

    if (state_q != ST_IDLE && (save_rise || rest_rise)) begin
      error_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        lin_addr_d = START_ADDRESS;
        cmd_word_d = '0;
        cmd_page_d = '0;
        out_word_d = '0;
        if (save_rise) begin
          state_d = ST_SAVE;
          if (rest_rise) error_d = 1'b1;
        end else if (rest_rise) begin
          state_d = ST_RESTORE;
        end
      end
      ST_SAVE: begin
        mem_cmd_valid = can_issue;
        dout_valid = (cnt_q != '0);
        if (can_issue && mem_cmd_ready && cmd_last) begin
          state_d = ST_SAVE_DRAIN;
        end
      end
      ST_SAVE_DRAIN: begin
        dout_valid = (cnt_q != '0);
        if (outst_q == '0 && cnt_q == '0) state_d = ST_DONE;
      end
      ST_RESTORE: begin
        mem_cmd_valid = din_valid;
        mem_cmd_we = 1'b1;
        din_ready = mem_cmd_ready;
        mem_wdata = (SWAP_BYTES != 0) ? swap_inv(din_data) : din_data;
        if (din_valid && mem_cmd_ready) begin
          if (din_last != page_end) error_d = 1'b1;
          if (cmd_last) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_fire = mem_cmd_valid && mem_cmd_ready;
    rd_fire = cmd_fire && !mem_cmd_we;
    if (cmd_fire) begin
      lin_addr_d = lin_addr_q + ADDR_W'(1);
      cmd_word_d = page_end ? '0 : cmd_word_q + PW_W'(1);
      if (page_end) cmd_page_d = cmd_page_q + 16'd1;
    end

    pop = dout_valid && dout_ready;
    dout_last = dout_valid && (out_word_q == LAST_WORD);
    if (pop) begin
      out_word_d = (out_word_q == LAST_WORD) ? '0 : out_word_q + PW_W'(1);
    end

    // A return with nothing outstanding cannot be matched to a word.
    rd_ok = mem_rvalid && (outst_q != '0);
    if (mem_rvalid && outst_q == '0) error_d = 1'b1;

    outst_d = outst_q + CNT_W'(rd_fire) - CNT_W'(rd_ok);
    cnt_d = cnt_q + CNT_W'(rd_ok) - CNT_W'(pop);
    wr_ptr_d = wr_ptr_q + FP_W'(rd_ok);
    rd_ptr_d = rd_ptr_q + FP_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      save_q <= 1'b0;
      restore_q <= 1'b0;
      error_q <= 1'b0;
      lin_addr_q <= START_ADDRESS;
      cmd_word_q <= '0;
      cmd_page_q <= '0;
      out_word_q <= '0;
      outst_q <= '0;
      cnt_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      save_q <= save_d;
      restore_q <= restore_d;
      error_q <= error_d;
      lin_addr_q <= lin_addr_d;
      cmd_word_q <= cmd_word_d;
      cmd_page_q <= cmd_page_d;
      out_word_q <= out_word_d;
      outst_q <= outst_d;
      cnt_q <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_ok) fifo_mem_q[wr_ptr_q] <= mem_rdata;
  end

endmodule

// File: tb/tb_mem_state_mover.sv
// Bench for mem_state_mover: small paged config, memory model with
// delayed in-order returns, scoreboard queues for commands and stream.
module tb_mem_state_mover;

  localparam int PW = 4;
  localparam int PC = 2;
  localparam int NW = PW * PC;

  logic clk = 1'b0;
  logic rst, save, restore;
  logic busy, done, error;
  logic mem_cmd_valid, mem_cmd_ready, mem_cmd_we;
  logic [1:0] mem_cmd_ch;
  logic [31:0] mem_cmd_addr;
  logic [127:0] mem_wdata;
  logic mem_rvalid;
  logic [127:0] mem_rdata;
  logic dout_valid, dout_ready, dout_last;
  logic [127:0] dout_data;
  logic din_valid, din_ready, din_last;
  logic [127:0] din_data;

  always #5 clk = ~clk;

  mem_state_mover #(
    .DATA_W(128),
    .ADDR_W(32),
    .NUM_CH(4),
    .PAGE_WORDS(PW),
    .PAGE_COUNT(PC),
    .START_ADDRESS(32'd6),
    .SWAP_BYTES(1),
    .FIFO_DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .save(save),
    .restore(restore),
    .busy(busy),
    .done(done),
    .error(error),
    .mem_cmd_valid(mem_cmd_valid),
    .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_we(mem_cmd_we),
    .mem_cmd_ch(mem_cmd_ch),
    .mem_cmd_addr(mem_cmd_addr),
    .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_data(dout_data),
    .dout_last(dout_last),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .din_data(din_data),
    .din_last(din_last)
  );

  typedef struct {
    logic [1:0] ch;
    logic [31:0] addr;
    logic last;
  } vec_t;

  typedef struct {
    logic we;
    logic [1:0] ch;
    logic [31:0] addr;
    logic [127:0] wdata;
  } cmd_t;

  typedef struct {
    logic [127:0] data;
    int due;
  } rd_t;

  vec_t vecs[NW];
  cmd_t exp_cmd[$];
  logic [127:0] exp_dout[$];
  rd_t rd_pend[$];
  logic [127:0] cap_q[$];

  int errors = 0;
  int checks = 0;
  int cyc_n = 0;
  int out_idx = 0;
  int done_cnt = 0;
  int rd_issued = 0;
  int wr_issued = 0;
  bit din_acc = 0;
  bit force_rv = 0;
  bit in_rst = 0;
  bit hold_pend = 0;
  logic hold_we;
  logic [1:0] hold_ch;
  logic [31:0] hold_addr;

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [127:0] mem_data(input logic [1:0] ch,
                                            input logic [31:0] addr);
    if (ch == 2'd2 && addr == 32'd1)
      return 128'h0F0E0D0C0B0A09080706050403020100;
    return {2{{30'd0, ch}, addr ^ 32'hA5C3_0000}};
  endfunction

  function automatic logic [127:0] swap_ref(input logic [127:0] w);
    logic [63:0] hi;
    logic [63:0] lo;
    for (int j = 0; j < 8; j++) begin
      hi[8*j +: 8] = w[16*j+8 +: 8];
      lo[8*j +: 8] = w[16*j +: 8];
    end
    return {hi, lo};
  endfunction

  task automatic tick();
    cmd_t c;
    if (force_rv) begin
      mem_rvalid = 1'b1;
      mem_rdata = '1;
    end else if (rd_pend.size() > 0 && rd_pend[0].due <= cyc_n) begin
      mem_rvalid = 1'b1;
      mem_rdata = rd_pend[0].data;
      exp_dout.push_back(swap_ref(rd_pend[0].data));
      rd_pend.delete(0);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata = '0;
    end
    #1;
    din_acc = 0;
    if (!in_rst) begin
      if (hold_pend)
        check("cmd_hold", {mem_cmd_valid, mem_cmd_we, mem_cmd_ch, mem_cmd_addr},
              {1'b1, hold_we, hold_ch, hold_addr});
      hold_pend = mem_cmd_valid && !mem_cmd_ready;
      hold_we = mem_cmd_we;
      hold_ch = mem_cmd_ch;
      hold_addr = mem_cmd_addr;
      if (mem_cmd_valid && mem_cmd_ready) begin
        if (exp_cmd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cmd_extra: got we=%0d ch=%0d addr=%0d expected no command",
                   mem_cmd_we, mem_cmd_ch, mem_cmd_addr);
        end else begin
          c = exp_cmd.pop_front();
          check("cmd", {mem_cmd_we, mem_cmd_ch, mem_cmd_addr}, {c.we, c.ch, c.addr});
          if (c.we) check("wdata", mem_wdata, c.wdata);
        end
        if (!mem_cmd_we) begin
          rd_issued++;
          rd_pend.push_back('{data: mem_data(mem_cmd_ch, mem_cmd_addr), due: cyc_n + 2});
        end else begin
          wr_issued++;
        end
      end
      if (din_valid && din_ready) din_acc = 1;
      if (dout_valid && dout_ready) begin
        cap_q.push_back(dout_data);
        if (exp_dout.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dout_extra: got %h expected no word", dout_data);
        end else begin
          check("dout", dout_data, exp_dout.pop_front());
        end
        check("dout_last", dout_last, vecs[out_idx % NW].last);
        out_idx++;
      end
      if (done) done_cnt++;
    end
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic clear_counts();
    out_idx = 0;
    done_cnt = 0;
    rd_issued = 0;
    wr_issued = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_rst = 1;
    mem_cmd_ready = 1'b0;
    dout_ready = 1'b0;
    din_valid = 1'b0;
    tick();
    rst = 1'b0;
    in_rst = 0;
    exp_cmd.delete();
    exp_dout.delete();
    rd_pend.delete();
    hold_pend = 0;
    clear_counts();
  endtask

  task automatic push_cmds(input logic we);
    for (int i = 0; i < NW; i++)
      exp_cmd.push_back('{we: we, ch: vecs[i].ch, addr: vecs[i].addr,
                          wdata: mem_data(vecs[i].ch, vecs[i].addr)});
  endtask

  task automatic run_until_done(input string name, input int limit);
    int n;
    int d0;
    n = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s_timeout: got no done in %0d cycles expected done", name, n);
    end
  endtask

  task automatic drive_restore(input string name, input int last_pos);
    int k;
    int n;
    k = 0;
    n = 0;
    while (k < NW && n < 200) begin
      din_valid = 1'b1;
      din_data = (k < cap_q.size()) ? cap_q[k] : '0;
      din_last = ((k % PW) == last_pos);
      mem_cmd_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
      if (din_acc) k++;
    end
    din_valid = 1'b0;
    din_last = 1'b0;
    mem_cmd_ready = 1'b1;
    checks++;
    if (k < NW) begin
      errors++;
      $display("FAIL %s_accept: got %0d words accepted expected %0d", name, k, NW);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int d0;
    rst = 1'b1;
    in_rst = 1;
    save = 1'b0;
    restore = 1'b0;
    mem_cmd_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    dout_ready = 1'b0;
    din_valid = 1'b0;
    din_data = '0;
    din_last = 1'b0;
    vecs = '{'{2'd2, 32'd1, 1'b0}, '{2'd3, 32'd1, 1'b0},
             '{2'd0, 32'd2, 1'b0}, '{2'd1, 32'd2, 1'b1},
             '{2'd2, 32'd2, 1'b0}, '{2'd3, 32'd2, 1'b0},
             '{2'd0, 32'd3, 1'b0}, '{2'd1, 32'd3, 1'b1}};
    @(negedge clk);
    do_reset();
    #1;
    check("reset_outs", {busy, done, error, mem_cmd_valid, dout_valid, din_ready}, 6'b0);

    // Save with everything ready: addresses, stream, last flags, swap.
    cap_q.delete();
    push_cmds(1'b0);
    mem_cmd_ready = 1'b1;
    dout_ready = 1'b1;
    save = 1'b1;
    tick();
    save = 1'b0;
    run_until_done("save1", 200);
    repeat (3) tick();
    check("save1_cmds_left", exp_cmd.size(), 0);
    check("save1_words", out_idx, NW);
    check("save1_done_once", done_cnt, 1);
    check("save1_busy", busy, 1'b0);
    check("save1_err", error, 1'b0);
    check("swap_word0", (cap_q.size() > 0) ? cap_q[0] : '0,
          128'h0F0D0B0907050301_0E0C0A0806040200);

    // Restore the saved stream with correct last flags.
    clear_counts();
    push_cmds(1'b1);
    restore = 1'b1;
    tick();
    restore = 1'b0;
    drive_restore("restore1", PW - 1);
    run_until_done("restore1", 20);
    repeat (2) tick();
    check("restore1_cmds_left", exp_cmd.size(), 0);
    check("restore1_writes", wr_issued, NW);
    check("restore1_err", error, 1'b0);
    check("restore1_done_once", done_cnt, 1);

    // Restore with din_last on the wrong word of each page.
    clear_counts();
    push_cmds(1'b1);
    restore = 1'b1;
    tick();
    restore = 1'b0;
    drive_restore("restore2", 2);
    run_until_done("restore2", 20);
    check("restore2_writes", wr_issued, NW);
    check("restore2_cmds_left", exp_cmd.size(), 0);
    check("restore2_err", error, 1'b1);

    // Backpressured save: read issue bounded by the buffer depth.
    do_reset();
    check("reset_clears_err", error, 1'b0);
    cap_q.delete();
    push_cmds(1'b0);
    mem_cmd_ready = 1'b1;
    dout_ready = 1'b0;
    save = 1'b1;
    tick();
    save = 1'b0;
    repeat (20) tick();
    check("stall_reads", rd_issued, 2);
    check("stall_dout_valid", dout_valid, 1'b1);
    restore = 1'b1;
    tick();
    restore = 1'b0;
    tick();
    check("busy_trigger_err", error, 1'b1);
    n = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < 400) begin
      dout_ready = 1'($urandom_range(0, 1));
      mem_cmd_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL stall_timeout: got no done in %0d cycles expected done", n);
    end
    check("stall_words", out_idx, NW);
    check("stall_cmds_left", exp_cmd.size(), 0);
    check("stall_dout_left", exp_dout.size(), 0);

    // Simultaneous triggers, then reset in the middle of the save.
    do_reset();
    push_cmds(1'b0);
    mem_cmd_ready = 1'b1;
    dout_ready = 1'b1;
    save = 1'b1;
    restore = 1'b1;
    tick();
    save = 1'b0;
    restore = 1'b0;
    check("both_trig", {busy, error, din_ready}, 3'b110);
    repeat (3) tick();
    do_reset();
    mem_cmd_ready = 1'b1;
    #1;
    check("abort_outs", {busy, done, error, mem_cmd_valid, dout_valid, din_ready}, 6'b0);

    // Read return with nothing outstanding.
    force_rv = 1;
    tick();
    force_rv = 0;
    tick();
    check("stray_rvalid", {error, dout_valid}, 2'b10);

    // Trigger held high through reset release starts a save.
    save = 1'b1;
    do_reset();
    push_cmds(1'b0);
    mem_cmd_ready = 1'b1;
    dout_ready = 1'b1;
    tick();
    check("held_trigger_busy", busy, 1'b1);
    run_until_done("held", 200);
    save = 1'b0;
    check("held_words", out_idx, NW);
    check("held_err", error, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
